fp4_operand_sequencer: RTL and testbench
========================================

Name: fp4_operand_sequencer

Overview:
- Upstream feeder for the fp4 e2m1 MAC.
- Accepts two lockstep streams of packed 32-bit words, one of weights and one of activations, each holding eight 4-bit e2m1 codes.
- Issues one weight/activation code pair per cycle to the MAC with its enable, clears the MAC accumulator at the start of each dot product, and flags when the accumulated result is valid.

Parameters:
- WORD_WIDTH, 32, packed input word width.
- ELEM_WIDTH, 4, fp4 code width (sign, exp[1:0], man).
- LANES, WORD_WIDTH/ELEM_WIDTH (8), codes per word. Derived; never overridden.
- LEN_WIDTH, 16, width of the dot-product length.
- MAC_LATENCY, 2, cycles from the last mac_en cycle to a valid MAC output (input register plus accumulator).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a dot product. Sampled only in IDLE.
- len  in  LEN_WIDTH  number of element pairs K. Latched with start.
- w_valid  in  1  weight word valid.
- w_ready  out  1  weight word accepted.
- w_data  in  WORD_WIDTH  packed weight codes. Lane 0 = bits [3:0] and is issued first.
- a_valid  in  1  activation word valid.
- a_ready  out  1  activation word accepted.
- a_data  in  WORD_WIDTH  packed activation codes. Same lane order as w_data.
- weight_o  out  ELEM_WIDTH  weight code to the MAC.
- act_o  out  ELEM_WIDTH  activation code to the MAC.
- mac_en  out  1  MAC enable. Asserted exactly K cycles per dot product.
- mac_clear  out  1  drives the MAC reset. One-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- result_valid  out  1  one-cycle pulse: MAC out holds the completed sum.

Behaviour:
- Reset: state IDLE; word buffers invalid; lane, element and drain counters zero. All outputs are 0 in the cycle after reset.
- Reset mid-operation aborts the run; no result_valid is produced.
- State IDLE:
  - start=1 latches len and moves to CLEAR.
  - start is ignored in every other state.
- State CLEAR (exactly 1 cycle):
  - mac_clear=1, mac_en=0.
  - Word loading is permitted, so the buffer can preload.
  - Next state: RUN if K>0, otherwise DRAIN.
- Word loading:
  - Weight and activation words are loaded together into buffers w_buf/a_buf, with buf_valid set.
  - load_slot = (CLEAR or RUN) and (not buf_valid, or issuing lane LANES-1 this cycle) and the remaining element count exceeds the codes left in the buffer.
  - w_ready = load_slot & a_valid; a_ready = load_slot & w_valid. A transfer occurs only when both sides handshake in the same cycle, so the streams never skew.
  - Loading on the cycle lane LANES-1 is issued gives zero-bubble streaming of one element per cycle.
- State RUN:
  - mac_en = buf_valid. weight_o/act_o are lane[lane_idx] of w_buf/a_buf, driven combinationally from registers.
  - Each issue increments lane_idx (wrapping at LANES, which clears buf_valid unless a reload happens that cycle) and decrements the remaining count.
  - No buffered word means mac_en=0 (bubble); weight_o/act_o may hold any value.
  - When the K-th element issues: go to DRAIN and invalidate the buffer. Unused upper lanes of the final word are discarded; no extra word is consumed.
- State DRAIN:
  - mac_en=0 and the ready outputs are low.
  - A counter runs MAC_LATENCY cycles.
  - result_valid=1 in cycle T_last+MAC_LATENCY, where T_last is the last mac_en cycle (or the CLEAR cycle when K=0). The state returns to IDLE in that same cycle.
- Simultaneous events:
  - A start in the same cycle as result_valid is ignored, because the state is not yet IDLE.
  - Back-to-back dot products therefore have a minimum 1 idle cycle between them.
- Width rules:
  - len is unsigned, so K up to 2^LEN_WIDTH-1.
  - The element counter is LEN_WIDTH wide.
  - lane_idx is clog2(LANES) wide.

Decomposition:
- Package fp4_seq_pkg holds:
  - localparam LANES;
  - typedef fp4_code_t (packed struct: sign, exp[1:0], man) matching the MAC's unpacked operand layout;
  - enum seq_state_t {IDLE, CLEAR, RUN, DRAIN}.
- One sub-module, fp4_word_unpacker, instantiated twice (weight and activation). It holds the word buffer and per-lane selection, with inputs load/data/lane_idx and output code.
- The top level owns the FSM, the counters and the handshake.

Test Plan:
- K=8, words w=0x76543210 and a=0xFEDCBA98 valid from cycle 0, start at cycle 0:
  - mac_clear at cycle 1;
  - mac_en high cycles 2–9, with weight_o 0..7 and act_o 8..F;
  - result_valid at cycle 11;
  - exactly one word accepted per side.
- K=20, three words per side streamed continuously: no mac_en bubbles across the word boundaries; lanes 4–7 of the third word are never issued; the third handshake completes; result_valid 2 cycles after the 20th issue.
- K=10 with a_valid deasserted for 3 cycles at the second word: mac_en low for those 3 cycles; w_ready stays low until a_valid returns; issue order is preserved; total mac_en count is 10.
- K=0: mac_clear pulse; no mac_en; no handshake; result_valid exactly MAC_LATENCY cycles after the CLEAR cycle.
- Reset asserted on the 4th mac_en cycle of K=16:
  - next cycle all outputs are 0 and busy=0, with no result_valid;
  - a new start then behaves as a fresh run.
- start pulsed during RUN and on the result_valid cycle: both ignored; a start one cycle later is accepted.

Source files
------------

// File: rtl/fp4_seq_pkg.sv
// Shared types and lane geometry for the fp4 e2m1 operand sequencer.
package fp4_seq_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ELEM_W = 4;
  localparam int unsigned LANES  = WORD_W / ELEM_W;
  localparam int unsigned LANE_W = $clog2(LANES);

  // Bit layout matches the MAC operand: {sign, exp[1:0], man}
  typedef struct packed {
    logic       sign;
    logic [1:0] exp;
    logic       man;
  } fp4_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/fp4_word_unpacker.sv
// Holds one packed operand word and presents the code of the selected lane.
module fp4_word_unpacker
  import fp4_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic [LANE_W-1:0] lane_idx,
  output fp4_code_t         code
);

  logic [WORD_W-1:0]             r_word;
  logic [LANES-1:0][ELEM_W-1:0]  w_lanes;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= '0;
    end else if (load) begin
      r_word <= data;
    end
  end

  // Lane 0 sits in the least significant nibble
  assign w_lanes = r_word;
  assign code    = fp4_code_t'(w_lanes[lane_idx]);

endmodule

// File: rtl/fp4_operand_sequencer.sv
// Streams weight/activation code pairs into the fp4 MAC, one pair per cycle,
// bracketing each dot product with an accumulator clear and a result strobe.
module fp4_operand_sequencer
  import fp4_seq_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned ELEM_WIDTH  = 4,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned MAC_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [WORD_WIDTH-1:0] w_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [WORD_WIDTH-1:0] a_data,
  output logic [ELEM_WIDTH-1:0] weight_o,
  output logic [ELEM_WIDTH-1:0] act_o,
  output logic                  mac_en,
  output logic                  mac_clear,
  output logic                  busy,
  output logic                  result_valid
);

  localparam int unsigned DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic [LANE_W-1:0]     r_lane;
  logic                  r_buf_valid;
  logic [DRAIN_W-1:0]    r_drain;

  logic                  w_issue;
  logic                  w_last;
  logic                  w_lane_end;
  logic                  w_load_slot;
  logic                  w_load;
  logic [LEN_WIDTH-1:0]  w_codes_left;
  fp4_code_t             w_wcode;
  fp4_code_t             w_acode;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake and MAC control
  always_comb begin
    w_state_nxt  = r_state;
    mac_clear    = 1'b0;
    result_valid = 1'b0;
    w_issue      = 1'b0;
    w_load_slot  = 1'b0;
    busy         = (r_state != IDLE);
    w_lane_end   = (r_lane == LANE_W'(LANES - 1));
    w_codes_left = r_buf_valid ? (LEN_WIDTH'(LANES) - LEN_WIDTH'(r_lane)) : '0;

    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = CLEAR;
      end
      CLEAR: begin
        mac_clear   = 1'b1;
        w_load_slot = !r_buf_valid && (r_remain > w_codes_left);
        w_state_nxt = (r_remain != '0) ? RUN : DRAIN;
      end
      RUN: begin
        w_issue     = r_buf_valid;
        // Refill when empty or while the last lane drains, but never past K
        w_load_slot = (!r_buf_valid || w_lane_end) && (r_remain > w_codes_left);
        if (r_buf_valid && (r_remain == LEN_WIDTH'(1))) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (r_drain == DRAIN_W'(MAC_LATENCY - 1)) begin
          result_valid = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_last  = w_issue && (r_remain == LEN_WIDTH'(1));
  assign w_ready = w_load_slot && a_valid;
  assign a_ready = w_load_slot && w_valid;
  assign w_load  = w_load_slot && w_valid && a_valid;
  assign mac_en  = w_issue;

  // Element, lane, buffer-valid and drain counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remain    <= '0;
      r_lane      <= '0;
      r_buf_valid <= 1'b0;
      r_drain     <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_remain <= len;
      end else if (w_issue) begin
        r_remain <= r_remain - LEN_WIDTH'(1);
      end

      if (w_last) begin
        r_lane <= '0;
      end else if (w_issue) begin
        r_lane <= r_lane + LANE_W'(1);
      end

      if (w_load) begin
        r_buf_valid <= 1'b1;
      end else if (w_last || (w_issue && w_lane_end)) begin
        r_buf_valid <= 1'b0;
      end

      if ((r_state == DRAIN) && !result_valid) begin
        r_drain <= r_drain + DRAIN_W'(1);
      end else begin
        r_drain <= '0;
      end
    end
  end

  fp4_word_unpacker u_w_unpack (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .data     (w_data),
    .lane_idx (r_lane),
    .code     (w_wcode)
  );

  fp4_word_unpacker u_a_unpack (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .data     (a_data),
    .lane_idx (r_lane),
    .code     (w_acode)
  );

  assign weight_o = w_wcode;
  assign act_o    = w_acode;

endmodule

// File: tb/tb_fp4_operand_sequencer.sv
// Scoreboard bench: accepted words queue their expected code pairs, mac_en pops them.
module tb_fp4_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] len;
  logic        w_valid, w_ready, a_valid, a_ready;
  logic [31:0] w_data, a_data;
  logic [3:0]  weight_o, act_o;
  logic        mac_en, mac_clear, busy, result_valid;

  fp4_operand_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .len          (len),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_data       (w_data),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_data       (a_data),
    .weight_o     (weight_o),
    .act_o        (act_o),
    .mac_en       (mac_en),
    .mac_clear    (mac_clear),
    .busy         (busy),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  sb[$];
  int          hs_tot = 0, mac_tot = 0, rv_tot = 0, clr_tot = 0, stall_tot = 0;
  int          pushed_tot = 0, push_lim = 0;
  int          last_mac_cyc = 0, rv_cyc = 0, clr_cyc = 0;
  int          hs_base = 0, stall_word = -1, stall_len = 0, stall_base = 0;
  logic [31:0] w_arr[4];
  logic [31:0] a_arr[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Sample DUT outputs on the falling edge
  task automatic mon();
    logic [7:0] e;
    @(negedge clk);
    if (reset) begin
      sb.delete();
      return;
    end
    if (w_ready && w_valid) begin
      chk("a_ready_pair", 32'(a_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
        if (pushed_tot < push_lim) begin
          sb.push_back({w_data[i*4 +: 4], a_data[i*4 +: 4]});
          pushed_tot++;
        end
      end
      hs_tot++;
    end
    if (a_ready && !a_valid) begin
      stall_tot++;
      chk("w_ready_stall", 32'(w_ready), 32'd0);
    end
    if (mac_en) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("weight_o", 32'(weight_o), 32'(e[7:4]));
        chk("act_o", 32'(act_o), 32'(e[3:0]));
      end
      mac_tot++;
      last_mac_cyc = cyc;
    end
    if (mac_clear) begin
      clr_tot++;
      clr_cyc = cyc;
    end
    if (result_valid) begin
      rv_tot++;
      rv_cyc = cyc;
    end
  endtask

  // Present the current word; a_valid drops while a stall is being applied
  task automatic drive();
    int wi;
    wi      = hs_tot - hs_base;
    w_valid = 1'b1;
    w_data  = w_arr[(wi > 3) ? 3 : wi];
    a_data  = a_arr[(wi > 3) ? 3 : wi];
    a_valid = !((wi == stall_word) && ((stall_tot - stall_base) < stall_len));
  endtask

  task automatic run_dot(input int k, input int sw, input int sl, input bit ign, input bit fixed);
    int c0, rel, mac0, rv0, clr0;
    for (int i = 0; i < 4; i++) begin
      w_arr[i] = $urandom;
      a_arr[i] = $urandom;
    end
    if (fixed) begin
      w_arr[0] = 32'h7654_3210;
      a_arr[0] = 32'hFEDC_BA98;
    end
    hs_base    = hs_tot;
    stall_word = sw;
    stall_len  = sl;
    stall_base = stall_tot;
    push_lim   = pushed_tot + k;
    mac0 = mac_tot;
    rv0  = rv_tot;
    clr0 = clr_tot;
    c0   = cyc;
    start = 1'b1;
    len   = 16'(k);
    drive();
    for (int n = 0; n < 300 && rv_tot == rv0; n++) begin
      mon();
      @(posedge clk);
      #1;
      rel   = cyc - c0;
      start = ign && ((rel == 5) || (rel == k + 3));
      len   = start ? 16'd3 : 16'(k);
      drive();
    end
    start = 1'b0;
    chk("rv_count", 32'(rv_tot - rv0), 32'd1);
    chk("clear_count", 32'(clr_tot - clr0), 32'd1);
    chk("clear_cycle", 32'(clr_cyc - c0), 32'd1);
    chk("mac_count", 32'(mac_tot - mac0), 32'(k));
    chk("words", 32'(hs_tot - hs_base), 32'((k + 7) / 8));
    if (k > 0) begin
      chk("issue_span", 32'(last_mac_cyc - clr_cyc), 32'(k + sl));
      chk("drain_lat", 32'(rv_cyc - last_mac_cyc), 32'd2);
    end else begin
      chk("drain_lat_k0", 32'(rv_cyc - clr_cyc), 32'd2);
    end
    chk("sb_left", 32'(sb.size()), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  task automatic reset_mid();
    int mac0, rv0;
    for (int i = 0; i < 4; i++) begin
      w_arr[i] = $urandom;
      a_arr[i] = $urandom;
    end
    hs_base    = hs_tot;
    stall_word = -1;
    push_lim   = pushed_tot + 16;
    mac0 = mac_tot;
    rv0  = rv_tot;
    start = 1'b1;
    len   = 16'd16;
    drive();
    for (int n = 0; n < 50 && (mac_tot - mac0) < 3; n++) begin
      mon();
      @(posedge clk);
      #1;
      start = 1'b0;
      drive();
    end
    chk("mac_before_reset", 32'(mac_tot - mac0), 32'd3);
    reset = 1'b1;
    mon();
    @(posedge clk);
    #1;
    reset    = 1'b0;
    push_lim = pushed_tot;
    @(negedge clk);
    chk("rst_mac_en", 32'(mac_en), 32'd0);
    chk("rst_mac_clear", 32'(mac_clear), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd0);
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_weight_o", 32'(weight_o), 32'd0);
    chk("rst_act_o", 32'(act_o), 32'd0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 6; n++) begin
      mon();
      @(posedge clk);
      #1;
      drive();
    end
    chk("no_rv_after_abort", 32'(rv_tot - rv0), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    len     = '0;
    w_valid = 1'b1;
    a_valid = 1'b1;
    w_data  = '0;
    a_data  = '0;
    for (int i = 0; i < 4; i++) begin
      w_arr[i] = '0;
      a_arr[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("init_mac_en", 32'(mac_en), 32'd0);
    chk("init_mac_clear", 32'(mac_clear), 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_result_valid", 32'(result_valid), 32'd0);
    chk("init_w_ready", 32'(w_ready), 32'd0);
    chk("init_a_ready", 32'(a_ready), 32'd0);
    chk("init_weight_o", 32'(weight_o), 32'd0);
    chk("init_act_o", 32'(act_o), 32'd0);
    @(posedge clk);
    #1;

    run_dot(8, -1, 0, 1'b0, 1'b1);
    run_dot(20, -1, 0, 1'b0, 1'b0);
    run_dot(10, 1, 3, 1'b0, 1'b0);
    run_dot(0, -1, 0, 1'b0, 1'b0);
    reset_mid();
    run_dot(16, -1, 0, 1'b0, 1'b0);
    run_dot(8, -1, 0, 1'b1, 1'b0);
    run_dot(8, -1, 0, 1'b0, 1'b0);
    run_dot(1, -1, 0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
